led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Multi-channel LED driver; generalises the single fixed-rate blinker to CH independent channels.
- Each channel has a runtime-selectable mode: OFF, ON, BLINK with programmable period, or PWM dim.
- A shared prescaler derives a slow tick from the board clock. A simple one-cycle write port configures channels.
- Sits between the control logic (button and UART handlers) and the board LED pins.

Parameters:
- CLK_HZ, 27000000, input clock frequency in Hz.
- TICK_HZ, 1000, prescaler tick rate in Hz. DIV = CLK_HZ/TICK_HZ must be >= 2.
- CH, 6, number of LED channels.
- PER_W, 16, width of the per-channel period field, in ticks.
- PWM_W, 8, width of the PWM counter and the duty field.
- LED_ACTIVE_LOW, 0, when 1 every oLED bit is inverted at the output register.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- iWrEn  in  1  single-cycle configuration write strobe.
- iWrCh  in  max(1,clog2(CH))  target channel index.
- iWrMode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- iWrPeriod  in  PER_W  BLINK half-period in ticks; also the breathe step interval.
- iWrDuty  in  PWM_W  PWM duty.
- oTick  out  1  one-cycle prescaler tick pulse.
- oLED  out  CH  registered LED outputs.

Behaviour:
- Reset (asynchronous, active-high):
  - Prescaler = 0, oTick = 0.
  - Every channel: mode OFF, tick counter 0, blink state 0, period 0, duty 0.
  - PWM counter = 0.
  - oLED = all 0, or all 1 when LED_ACTIVE_LOW = 1.
  - Asserting RESET mid-operation aborts everything immediately; no state survives.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - oTick is registered and is 1 for exactly the cycle after the counter equals DIV-1, so its period is DIV cycles.
  - Free-running; writes never disturb it.
- PWM counter: a free-running PWM_W-bit counter that increments every clock and wraps from 2^PWM_W-1 to 0. It is shared by all channels.
- Write:
  - When iWrEn=1 and iWrCh<CH, the target channel's mode, period and duty are loaded at that edge.
  - The same write clears that channel's tick counter, blink state and breathe level.
  - When iWrCh>=CH the write is ignored.
  - A write to channel k does not affect any other channel.
- A period of 0 is treated as 1.
- Per-channel output (before polarity), registered with 1-cycle latency from the state change:
  - OFF: 0.
  - ON: 1.
  - BLINK: on each oTick, if the tick counter equals period-1, the counter clears and the blink state toggles; otherwise the counter increments. The output is the blink state, giving a full cycle of 2*period ticks.
  - PWM: output is (pwm_cnt < duty). Duty 0 gives constant 0; duty 2^PWM_W-1 gives 255/256 on-time at PWM_W=8.
- Simultaneous write and oTick on the same channel: the write wins and the tick is discarded for that channel only.
- Write-to-output latency: ON/OFF reach oLED on the edge after the write edge.
- Prescaler and tick counters must never overflow; the wrap values above are exact.

Optional Feature:
- Macro: LED_BREATHE_EN.
- Defined: mode 3 becomes BREATHE.
  - A per-channel PWM_W-bit level starts at 0 with direction up.
  - On each tick where the tick counter equals period-1, the counter clears and the level steps by 1 in the current direction.
  - At 2^PWM_W-1 the direction flips to down; at 0 it flips to up. The endpoints are held for one step each; there is no overshoot.
  - Output is (pwm_cnt < level). iWrDuty is ignored.
- Undefined: mode 3 is static PWM at iWrDuty as specified above. No level registers are synthesised.

Test Plan (bench parameters: CLK_HZ=100, TICK_HZ=10 so DIV=10; CH=6, PWM_W=8):
- Reset release -> oTick pulses 1 cycle wide every 10 cycles; oLED=6'b000000. With LED_ACTIVE_LOW=1 -> oLED=6'b111111.
- Write ch2 ON -> oLED[2]=1 one cycle after the write edge. Write ch2 OFF -> oLED[2]=0 one cycle later. All other bits stay 0.
- Write ch0 BLINK period=3 -> oLED[0] toggles every 3 ticks (30 cycles). First rise at the 3rd tick after the write. Period=0 -> toggles every tick.
- Write ch1 PWM duty=64 -> oLED[1] high for exactly 64 of every 256 cycles. Duty=0 -> constant 0. Duty=255 -> 255 of 256.
- Write coincident with oTick, and a write with iWrCh=7 -> the coincident tick is not counted for the target channel; the iWrCh=7 write changes nothing. Assert RESET mid-blink -> all outputs are inactive immediately.
- LED_BREATHE_EN defined, ch3 mode 3 period=1 -> level ramps 0..255..0 over 510 ticks. Duty measured over 256 cycles tracks the level.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM modes driven by a shared tick prescaler and PWM counter.
// Defining LED_BREATHE_EN turns mode 3 into a triangular breathe ramp instead of static PWM duty.
module led_pattern_gen #(
  parameter int CLK_HZ         = 27000000,
  parameter int TICK_HZ        = 1000,
  parameter int CH             = 6,
  parameter int PER_W          = 16,
  parameter int PWM_W          = 8,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 iWrEn,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] iWrCh,
  input  logic [1:0]                           iWrMode,
  input  logic [PER_W-1:0]                     iWrPeriod,
  input  logic [PWM_W-1:0]                     iWrDuty,
  output logic                                 oTick,
  output logic [CH-1:0]                        oLED
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CH-1:0] POL = (LED_ACTIVE_LOW != 0) ? {CH{1'b1}} : {CH{1'b0}};

  typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_PWM = 2'd3} mode_e;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  mode_e            mode_q [CH];
  mode_e            mode_d [CH];
  logic [PER_W-1:0] per_q [CH];
  logic [PER_W-1:0] per_d [CH];
  logic [PER_W-1:0] cnt_q [CH];
  logic [PER_W-1:0] cnt_d [CH];
  logic [PWM_W-1:0] duty_q [CH];
  logic [PWM_W-1:0] duty_d [CH];
  logic [CH-1:0]    blink_q, blink_d, led_q, led_d;
  logic [CH-1:0]    wr_sel, last, on_raw;
`ifdef LED_BREATHE_EN
  localparam logic [PWM_W-1:0] LVL_TOP = {PWM_W{1'b1}};
  logic [PWM_W-1:0] level_q [CH];
  logic [PWM_W-1:0] level_d [CH];
  logic [CH-1:0]    dir_q, dir_d;
`endif

  always_comb begin
    presc_d = (presc_q == PS_W'(DIV - 1)) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_q == PS_W'(DIV - 1));
    pwm_d   = pwm_q + 1'b1;
    wr_sel  = '0;
    last    = '0;
    on_raw  = '0;
    blink_d = blink_q;
    led_d   = POL;
`ifdef LED_BREATHE_EN
    dir_d   = dir_q;
`endif
    for (int i = 0; i < CH; i++) begin
      mode_d[i] = mode_q[i];
      per_d[i]  = per_q[i];
      duty_d[i] = duty_q[i];
      cnt_d[i]  = cnt_q[i];
`ifdef LED_BREATHE_EN
      level_d[i] = level_q[i];
`endif
      // Out-of-range channel indices never match, so such writes fall through.
      wr_sel[i] = iWrEn && (32'(iWrCh) == 32'(i));
      // Period 0 behaves as 1: every tick is the last one.
      last[i]   = (per_q[i] <= PER_W'(1)) || (cnt_q[i] == per_q[i] - 1'b1);
      if (wr_sel[i]) begin
        mode_d[i]  = mode_e'(iWrMode);
        per_d[i]   = iWrPeriod;
        duty_d[i]  = iWrDuty;
        cnt_d[i]   = '0;
        blink_d[i] = 1'b0;
`ifdef LED_BREATHE_EN
        level_d[i] = '0;
        dir_d[i]   = 1'b0;
`endif
      end else if (tick_q) begin
        cnt_d[i] = last[i] ? '0 : cnt_q[i] + 1'b1;
        if (last[i] && mode_q[i] == M_BLINK) blink_d[i] = ~blink_q[i];
`ifdef LED_BREATHE_EN
        if (last[i] && mode_q[i] == M_PWM) begin
          if (dir_q[i]) begin
            level_d[i] = level_q[i] - 1'b1;
            if (level_q[i] == PWM_W'(1)) dir_d[i] = 1'b0;
          end else begin
            level_d[i] = level_q[i] + 1'b1;
            if (level_q[i] == LVL_TOP - 1'b1) dir_d[i] = 1'b1;
          end
        end
`endif
      end
      case (mode_q[i])
        M_OFF:   on_raw[i] = 1'b0;
        M_ON:    on_raw[i] = 1'b1;
        M_BLINK: on_raw[i] = blink_q[i];
`ifdef LED_BREATHE_EN
        M_PWM:   on_raw[i] = (pwm_q < level_q[i]);
`else
        M_PWM:   on_raw[i] = (pwm_q < duty_q[i]);
`endif
        default: on_raw[i] = 1'b0;
      endcase
      led_d[i] = on_raw[i] ^ POL[i];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
      blink_q <= '0;
      led_q   <= POL;
`ifdef LED_BREATHE_EN
      dir_q   <= '0;
`endif
      for (int i = 0; i < CH; i++) begin
        mode_q[i] <= M_OFF;
        per_q[i]  <= '0;
        duty_q[i] <= '0;
        cnt_q[i]  <= '0;
`ifdef LED_BREATHE_EN
        level_q[i] <= '0;
`endif
      end
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
      blink_q <= blink_d;
      led_q   <= led_d;
`ifdef LED_BREATHE_EN
      dir_q   <= dir_d;
`endif
      for (int i = 0; i < CH; i++) begin
        mode_q[i] <= mode_d[i];
        per_q[i]  <= per_d[i];
        duty_q[i] <= duty_d[i];
        cnt_q[i]  <= cnt_d[i];
`ifdef LED_BREATHE_EN
        level_q[i] <= level_d[i];
`endif
      end
    end
  end

  assign oTick = tick_q;
  assign oLED  = led_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed steps plus random writes, checked every cycle against an arithmetic model.
`timescale 1ns/1ps
module tb_led_pattern_gen;
  localparam int CLK_HZ = 100, TICK_HZ = 10, DIV = 10, CH = 6, PER_W = 16, PWM_W = 8;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             iWrEn = 1'b0;
  logic [2:0]       iWrCh = '0;
  logic [1:0]       iWrMode = '0;
  logic [PER_W-1:0] iWrPeriod = '0;
  logic [PWM_W-1:0] iWrDuty = '0;
  logic             oTick, oTick_al;
  logic [CH-1:0]    oLED, oLED_al;

  led_pattern_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CH(CH), .PER_W(PER_W), .PWM_W(PWM_W),
                    .LED_ACTIVE_LOW(0)) dut (
    .CLK(CLK), .RESET(RESET), .iWrEn(iWrEn), .iWrCh(iWrCh), .iWrMode(iWrMode),
    .iWrPeriod(iWrPeriod), .iWrDuty(iWrDuty), .oTick(oTick), .oLED(oLED));

  led_pattern_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CH(CH), .PER_W(PER_W), .PWM_W(PWM_W),
                    .LED_ACTIVE_LOW(1)) dut_al (
    .CLK(CLK), .RESET(RESET), .iWrEn(iWrEn), .iWrCh(iWrCh), .iWrMode(iWrMode),
    .iWrPeriod(iWrPeriod), .iWrDuty(iWrDuty), .oTick(oTick_al), .oLED(oLED_al));

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Model state: edges since reset release, and per channel the settings plus ticks seen since the last write.
  int            e;
  int            m_mode [CH];
  int            m_per  [CH];
  int            m_duty [CH];
  int            m_nt   [CH];
  logic [CH-1:0] exp_led;
  logic          exp_tick;

  function automatic void model_reset();
    e = 0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_nt[c] = 0;
    end
    exp_led  = '0;
    exp_tick = 1'b0;
  endfunction

  function automatic logic ch_out(int c, int pwm);
    int p, s, m, lvl;
    p = (m_per[c] == 0) ? 1 : m_per[c];
    s = m_nt[c] / p;
    m = s % 510;
    lvl = (m <= 255) ? m : 510 - m;
    case (m_mode[c])
      1: return 1'b1;
      2: return ((s % 2) == 1);
`ifdef LED_BREATHE_EN
      3: return (pwm < lvl);
`else
      3: return (pwm < m_duty[c]);
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Outputs after edge e reflect channel state and PWM count as they stood before edge e.
  function automatic void model_edge();
    logic tk;
    e++;
    tk = (e > 1) && (((e - 1) % DIV) == 0);
    for (int c = 0; c < CH; c++) exp_led[c] = ch_out(c, (e - 1) % 256);
    for (int c = 0; c < CH; c++) begin
      if (iWrEn && int'(iWrCh) == c) begin
        m_mode[c] = int'(iWrMode); m_per[c] = int'(iWrPeriod);
        m_duty[c] = int'(iWrDuty); m_nt[c] = 0;
      end else if (tk) begin
        m_nt[c]++;
      end
    end
    exp_tick = ((e % DIV) == 0);
  endfunction

  task automatic check_outputs();
    checks++;
    assert (oLED === exp_led) else begin
      failures++; $error("FAIL led: observed=%b expected=%b edge=%0d", oLED, exp_led, e);
    end
    checks++;
    assert (oLED_al === ~exp_led) else begin
      failures++; $error("FAIL led_al: observed=%b expected=%b edge=%0d", oLED_al, ~exp_led, e);
    end
    checks++;
    assert (oTick === exp_tick && oTick_al === exp_tick) else begin
      failures++; $error("FAIL tick: observed=%b/%b expected=%b edge=%0d", oTick, oTick_al, exp_tick, e);
    end
  endtask

  task automatic chk(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      failures++; $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic wr(int ch, int mode, int per, int duty);
    iWrEn = 1'b1; iWrCh = 3'(ch); iWrMode = 2'(mode);
    iWrPeriod = PER_W'(per); iWrDuty = PWM_W'(duty);
    cyc();
    iWrEn = 1'b0;
  endtask

  // Cycles from now until oLED[ch] next equals val; returns -1 if the bound expires.
  task automatic wait_led(int ch, logic val, int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      cyc();
      if (oLED[ch] === val) begin n = k; break; end
    end
  endtask

  initial begin
    int n, highs;
    model_reset();
    repeat (3) begin @(negedge CLK); check_outputs(); end
    RESET = 1'b0;

    // Tick cadence
    highs = 0;
    for (int k = 0; k < 100; k++) begin cyc(); if (oTick) highs++; end
    chk("tick_count_100", highs, 10);

    // ON/OFF latency
    wr(2, 1, 0, 0);
    chk("on_same_edge", int'(oLED), 0);
    cyc();
    chk("on_next_edge", int'(oLED), 6'b000100);
    wr(2, 0, 0, 0);
    chk("off_same_edge", int'(oLED), 6'b000100);
    cyc();
    chk("off_next_edge", int'(oLED), 0);

    // Blink period 3, then period 0
    wr(0, 2, 3, 0);
    wait_led(0, 1'b1, 60, n);
    chk("blink3_rise_found", int'(n > 0), 1);
    wait_led(0, 1'b0, 60, n);
    chk("blink3_half", n, 30);
    wait_led(0, 1'b1, 60, n);
    chk("blink3_half2", n, 30);
    wr(0, 2, 0, 0);
    wait_led(0, 1'b1, 30, n);
    chk("blink0_rise_found", int'(n > 0), 1);
    wait_led(0, 1'b0, 30, n);
    chk("blink0_half", n, 10);

    // PWM duty
    wr(1, 3, 0, 64);
    cyc();
    highs = 0;
    for (int k = 0; k < 256; k++) begin cyc(); if (oLED[1]) highs++; end
`ifndef LED_BREATHE_EN
    chk("pwm64", highs, 64);
`endif
    wr(1, 3, 0, 0);
    cyc();
    highs = 0;
    for (int k = 0; k < 256; k++) begin cyc(); if (oLED[1]) highs++; end
`ifndef LED_BREATHE_EN
    chk("pwm0", highs, 0);
`endif
    wr(1, 3, 0, 255);
    cyc();
    highs = 0;
    for (int k = 0; k < 256; k++) begin cyc(); if (oLED[1]) highs++; end
`ifndef LED_BREATHE_EN
    chk("pwm255", highs, 255);
`endif

    // Write coincident with a tick: that tick must not count
    n = 0;
    for (int k = 0; k < 20 && !oTick; k++) cyc();
    chk("tick_seen", int'(oTick), 1);
    wr(4, 2, 2, 0);
    wait_led(4, 1'b1, 40, n);
    chk("coincident_first_rise", n, 21);

    // Out-of-range channel is ignored
    wr(7, 1, 5, 200);
    repeat (20) cyc();

    // Random writes
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        wr(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
           int'($urandom_range(4, 0)), int'($urandom_range(255, 0)));
      end else begin
        cyc();
      end
    end

    // Reset mid-blink
    wr(0, 2, 1, 0);
    wait_led(0, 1'b1, 40, n);
    chk("pre_reset_high", int'(oLED[0]), 1);
    #2 RESET = 1'b1;
    #1;
    chk("mid_reset_led", int'(oLED), 0);
    chk("mid_reset_led_al", int'(oLED_al), 6'b111111);
    chk("mid_reset_tick", int'(oTick), 0);
    model_reset();
    repeat (2) begin @(negedge CLK); check_outputs(); end
    RESET = 1'b0;
    repeat (40) cyc();
    chk("post_reset_led", int'(oLED), 0);

`ifdef LED_BREATHE_EN
    // Breathe ramp over a full 510-step cycle
    wr(3, 3, 1, 0);
    repeat (5200) cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
